// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared opcodes and pipeline field widths for fetch and decode
package fetch_queue_pkg;

    localparam int IR_W        = 32;
    localparam int PC_W        = 8;
    localparam int OP_W        = 6;

    localparam logic [OP_W-1:0] OP_NOP  = 6'b000000;
    localparam logic [OP_W-1:0] OP_JMP  = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OP_W-1:0] OP_BLT  = 6'b000101;
    localparam logic [OP_W-1:0] OP_BGT  = 6'b000110;
    localparam logic [OP_W-1:0] OP_HALT = 6'b111111;

    function automatic logic [OP_W-1:0] op_of(input logic [IR_W-1:0] ir);
        return ir[IR_W-1 -: OP_W];
    endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// rtl/fetch_queue_fifo.sv - shift-register FIFO whose entry 0 is the registered head
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 40
) (
    input  logic                         clk1,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic             do_pop;
    logic [IDX_W-1:0] wr_pos;

    // With a same-cycle pop the incoming word lands one slot lower, behind the shifted entries.
    assign do_pop = pop && (count != '0);
    assign wr_pos = count[IDX_W-1:0] - IDX_W'(do_pop);
    assign head   = mem[0];

    always_ff @(posedge clk1) begin
        if (reset) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
        end else begin
            if (do_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
            end
            if (push) begin
                mem[wr_pos] <= push_data;
            end
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end: PC, memory requests, buffering, redirect and halt
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [OP_W-1:0]   HALT_OP  = OP_HALT
) (
    input  logic              clk1,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [IR_W-1:0]   imem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [IR_W-1:0]   if_ir,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_npc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = IR_W + ADDR_W;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              inflight;
    logic              fetch_stop;
    logic              head_loaded;
    logic [CNT_W-1:0]  count;
    logic [ENT_W-1:0]  head;
    logic [CNT_W:0]    occupancy;
    logic              redirect;
    logic              resp;
    logic              halt_resp;
    logic              pop;

    assign redirect  = redirect_valid && !halted;
    assign resp      = inflight && !redirect;
    assign halt_resp = resp && (op_of(imem_rdata) == HALT_OP);
    assign occupancy = {1'b0, count} + (CNT_W+1)'(inflight);

    // A Halt arriving this cycle already blocks the next request, so nothing past it is fetched.
    assign imem_req  = !reset && !redirect_valid && !fetch_stop && !halt_resp && !halted
                       && (occupancy < (CNT_W+1)'(DEPTH));
    assign imem_addr = pc;

    assign if_valid  = (count != '0) && !halted;
    assign if_ir     = head[ENT_W-1:ADDR_W];
    assign if_pc     = head[ADDR_W-1:0];
    assign if_npc    = head_loaded ? if_pc + ADDR_W'(1) : '0;
    assign pop       = if_valid && if_ready && !redirect;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk1      (clk1),
        .reset     (reset),
        .flush     (redirect),
        .push      (resp),
        .push_data ({imem_rdata, req_pc}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clk1) begin
        if (reset) begin
            pc          <= RESET_PC;
            req_pc      <= '0;
            inflight    <= 1'b0;
            fetch_stop  <= 1'b0;
            head_loaded <= 1'b0;
            halted      <= 1'b0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc     <= pc + ADDR_W'(1);
                req_pc <= pc;
            end
            if (resp) begin
                head_loaded <= 1'b1;
            end
            // A flushed Halt was speculative, so a redirect re-enables fetch.
            if (redirect) begin
                pc         <= redirect_pc;
                fetch_stop <= 1'b0;
            end else if (halt_resp) begin
                fetch_stop <= 1'b1;
            end
            if (pop && (op_of(if_ir) == HALT_OP)) begin
                halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue against a sequential-program model
module tb_fetch_queue;

    localparam int         ADDR_W = 8;
    localparam int         DEPTH  = 4;
    localparam logic [5:0] HALT   = 6'b111111;

    logic              clk1 = 1'b0;
    logic              reset;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_ir;
    logic [ADDR_W-1:0] if_pc;
    logic [ADDR_W-1:0] if_npc;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halted;

    logic [31:0] mem [256];
    int          n_checks = 0;
    int          n_pass   = 0;

    // Program-order model: decode must see consecutive words from the last restart point.
    logic [7:0] exp_pc;
    logic [7:0] fetch_pc;
    int         issued;
    int         accepted;
    int         total_acc;
    bit         model_halted;
    bit         halt_requested;

    logic        s_req, s_valid, s_halted;
    logic [7:0]  s_addr, s_pc, s_npc;
    logic [31:0] s_ir;

    always #5 clk1 = ~clk1;

    fetch_queue #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (8'd0),
        .HALT_OP  (HALT)
    ) dut (
        .clk1           (clk1),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_ir          (if_ir),
        .if_pc          (if_pc),
        .if_npc         (if_npc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    always @(posedge clk1) begin
        imem_rdata <= imem_req ? mem[imem_addr] : $urandom;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_restart(input logic [7:0] start);
        exp_pc         = start;
        fetch_pc       = start;
        issued         = 0;
        accepted       = 0;
        halt_requested = 0;
    endtask

    task automatic model_step(input logic rdy, input logic rv, input logic [7:0] rpc);
        logic [7:0] nx;
        check("halted", halted, model_halted);
        if (model_halted) begin
            check("valid_after_halt", if_valid, 1'b0);
            check("req_after_halted", imem_req, 1'b0);
        end
        if (halt_requested) check("req_after_halt_fetch", imem_req, 1'b0);
        if (rv && !model_halted) check("req_on_redirect", imem_req, 1'b0);
        if (imem_req) begin
            check("req_addr", imem_addr, fetch_pc);
            issued++;
            check("no_overflow", (issued - accepted) <= DEPTH, 1'b1);
            if (mem[fetch_pc][31:26] == HALT) halt_requested = 1;
            fetch_pc++;
        end
        if (if_valid && rdy && !rv) begin
            nx = exp_pc + 8'd1;
            check("ir", if_ir, mem[exp_pc]);
            check("pc", if_pc, exp_pc);
            check("npc", if_npc, nx);
            if (mem[exp_pc][31:26] == HALT) model_halted = 1;
            exp_pc = nx;
            accepted++;
            total_acc++;
        end
        if (rv && !model_halted) model_restart(rpc);
    endtask

    task automatic cycle(input logic rdy, input logic rv, input logic [7:0] rpc);
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        s_req    = imem_req;
        s_addr   = imem_addr;
        s_valid  = if_valid;
        s_ir     = if_ir;
        s_pc     = if_pc;
        s_npc    = if_npc;
        s_halted = halted;
        model_step(rdy, rv, rpc);
        @(negedge clk1);
        #1;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        @(negedge clk1);
        #1;
        @(negedge clk1);
        #1;
        check("rst_valid", if_valid, 1'b0);
        check("rst_req", imem_req, 1'b0);
        check("rst_ir", if_ir, 32'h0);
        check("rst_pc", if_pc, 8'h0);
        check("rst_npc", if_npc, 8'h0);
        check("rst_halted", halted, 1'b0);
        reset        = 1'b0;
        model_halted = 0;
        model_restart(8'd0);
    endtask

    task automatic fill_linear();
        for (int i = 0; i < 256; i++) mem[i] = 32'h100 + i;
    endtask

    initial begin
        int halt_wait;
        fill_linear();

        // streaming from reset
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            cycle(1'b1, 1'b0, 8'h0);
            if (k == 1) check("first_req", s_req, 1'b1);
            if (k < 3) check("not_yet_valid", s_valid, 1'b0);
            else check("stream_valid", s_valid, 1'b1);
            if (k == 3) check("first_ir", s_ir, 32'h100);
        end

        // backpressure then drain
        do_reset();
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 8'h0);
        check("hold_req", s_req, 1'b0);
        check("hold_valid", s_valid, 1'b1);
        check("hold_head", s_ir, 32'h100);
        check("hold_buffered", issued - accepted, DEPTH);
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 8'h0);
        check("drain_progress", accepted >= 4, 1'b1);

        // redirect with three queued and one in flight
        do_reset();
        for (int k = 1; k <= 4; k++) cycle(1'b0, 1'b0, 8'h0);
        check("redir_setup", issued, 4);
        cycle(1'b0, 1'b1, 8'h40);
        cycle(1'b1, 1'b0, 8'h0);
        check("redir_t1_valid", s_valid, 1'b0);
        check("redir_t1_req", s_req, 1'b1);
        check("redir_t1_addr", s_addr, 8'h40);
        cycle(1'b1, 1'b0, 8'h0);
        check("redir_t2_valid", s_valid, 1'b0);
        cycle(1'b1, 1'b0, 8'h0);
        check("redir_t3_valid", s_valid, 1'b1);
        check("redir_t3_ir", s_ir, 32'h140);
        check("redir_t3_pc", s_pc, 8'h40);

        // halt at address 5
        mem[5] = {HALT, 26'h5};
        do_reset();
        for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0, 8'h0);
        check("halt_halted", s_halted, 1'b1);
        check("halt_valid", s_valid, 1'b0);
        check("halt_last_fetch", fetch_pc, 8'd6);

        // speculative halt flushed by redirect
        do_reset();
        for (int k = 0; k < 20 && accepted < 3; k++) cycle(1'b1, 1'b0, 8'h0);
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 8'h0);
        check("spec_fetch_stop", fetch_pc, 8'd6);
        cycle(1'b0, 1'b1, 8'h20);
        for (int k = 0; k < 15; k++) cycle(1'b1, 1'b0, 8'h0);
        check("spec_not_halted", s_halted, 1'b0);
        check("spec_resumed", exp_pc > 8'h25, 1'b1);
        mem[5] = 32'h105;

        // PC wrap
        do_reset();
        cycle(1'b1, 1'b1, 8'd254);
        for (int k = 2; k <= 11; k++) begin
            cycle(1'b1, 1'b0, 8'h0);
            if (k == 5) begin
                check("wrap_pc", s_pc, 8'd255);
                check("wrap_npc", s_npc, 8'd0);
            end
        end
        check("wrap_end", exp_pc, 8'd6);

        // randomized program, readiness, redirects and resets
        for (int i = 0; i < 256; i++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 31) == 0) ? HALT : 6'($urandom_range(0, 62));
            mem[i] = {op, 26'($urandom)};
        end
        do_reset();
        total_acc = 0;
        halt_wait = 0;
        for (int i = 0; i < 3000; i++) begin
            halt_wait = model_halted ? halt_wait + 1 : 0;
            if (halt_wait > 5 || $urandom_range(0, 499) == 0) begin
                do_reset();
                halt_wait = 0;
            end
            cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), 8'($urandom));
        end
        check("random_progress", total_acc > 200, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
